// File: rtl/mod_mult_result_checker.sv
// Golden checker for a ModMult DUT: recomputes A*B mod q bit-serially (MSB first, double-and-add)
// and compares the result with the DUT's C, keeping saturating pass/fail statistics.
module mod_mult_result_checker #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] C,
    output logic              res_valid,
    output logic              res_match,
    output logic              res_op_err,
    output logic [DATA_W-1:0] res_expected,
    output logic [CNT_W-1:0]  chk_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              fail,
    output logic [1:0]        dbg_state_o
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CHK  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Handshake: a tuple is taken on a cycle where in_valid && in_ready; in_ready is high
    // only in IDLE, so in_valid during a check is ignored and the inputs are then don't-care.

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, b_q, m_q, c_q;
    logic [DATA_W:0]   r_q;
    logic [IDX_W-1:0]  idx_q;
    logic              match_q, op_err_q, fail_q;
    logic [DATA_W-1:0] exp_q;
    logic [CNT_W-1:0]  chk_q, err_q;

    logic              illegal;
    logic [DATA_W:0]   m_ext, a_ext, r_dbl, r_red, r_add, r_nxt;
    logic              verdict_en, v_match, v_op_err;
    logic [DATA_W-1:0] v_exp;

    assign illegal = (m_q < DATA_W'(2)) || (a_q >= m_q) || (b_q >= m_q);

    // R stays below q, so the doubled and added values fit in DATA_W+1 bits.
    assign m_ext = {1'b0, m_q};
    assign a_ext = {1'b0, a_q};
    assign r_dbl = {r_q[DATA_W-1:0], 1'b0};
    assign r_red = (r_dbl >= m_ext) ? (r_dbl - m_ext) : r_dbl;
    assign r_add = b_q[idx_q] ? (r_red + a_ext) : r_red;
    assign r_nxt = (r_add >= m_ext) ? (r_add - m_ext) : r_add;

    assign verdict_en = ((state_q == ST_CHK) && illegal) ||
                        ((state_q == ST_RUN) && (idx_q == '0));
    assign v_op_err   = (state_q == ST_CHK);
    assign v_exp      = v_op_err ? '0 : r_nxt[DATA_W-1:0];
    assign v_match    = !v_op_err && (r_nxt[DATA_W-1:0] == c_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_CHK;
            ST_CHK:  state_d = illegal ? ST_DONE : ST_RUN;
            ST_RUN:  if (idx_q == '0) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            match_q  <= 1'b0;
            op_err_q <= 1'b0;
            exp_q    <= '0;
            chk_q    <= '0;
            err_q    <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && in_valid) begin
                a_q <= A;
                b_q <= B;
                m_q <= q;
                c_q <= C;
            end
            if (state_q == ST_CHK) begin
                r_q   <= '0;
                idx_q <= IDX_W'(DATA_W - 1);
            end else if (state_q == ST_RUN) begin
                r_q   <= r_nxt;
                idx_q <= idx_q - 1'b1;
            end
            // Verdict and statistics are registered on entry to DONE so they are valid with res_valid.
            if (verdict_en) begin
                match_q  <= v_match;
                op_err_q <= v_op_err;
                exp_q    <= v_exp;
                if (!(&chk_q)) chk_q <= chk_q + CNT_W'(1);
                if (!v_match) begin
                    if (!(&err_q)) err_q <= err_q + CNT_W'(1);
                    fail_q <= 1'b1;
                end
            end
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign res_valid    = (state_q == ST_DONE);
    assign res_match    = match_q;
    assign res_op_err   = op_err_q;
    assign res_expected = exp_q;
    assign chk_cnt      = chk_q;
    assign err_cnt      = err_q;
    assign fail         = fail_q;
    assign dbg_state_o  = state_q;

endmodule
